// File: rtl/lampFPU_pkg.sv
// lampFPU_pkg: shared widths, special constants, sqrt sequencer state and operand class
package lampFPU_pkg;
  localparam int LAMP_FLOAT_DW = 16;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam logic [LAMP_FLOAT_DW-1:0] QNAN = 16'h7FC0;
  localparam logic [LAMP_FLOAT_DW-1:0] PINF = 16'h7F80;
  localparam logic [LAMP_FLOAT_E_DW-1:0] BIAS = 8'd127;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PACK, OUT} state_t;
  typedef struct packed {
    logic is_nan;
    logic is_zero;
    logic is_inf;
    logic is_neg;
  } class_t;
endpackage

// File: rtl/lampfpu_sqrt_issue_if.sv
// lampfpu_sqrt_issue_if: operand/result handshake bundle; flags_o exists only with LAMP_SQRT_FLAGS_EN
interface lampfpu_sqrt_issue_if;
  import lampFPU_pkg::*;
  logic in_valid_i;
  logic in_ready_o;
  logic [LAMP_FLOAT_DW-1:0] op_i;
  logic inv_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [LAMP_FLOAT_DW-1:0] res_o;
`ifdef LAMP_SQRT_FLAGS_EN
  logic [1:0] flags_o;
`endif
  modport master (
    output in_valid_i, op_i, inv_i, out_ready_i,
    input in_ready_o, out_valid_o, res_o
`ifdef LAMP_SQRT_FLAGS_EN
    , flags_o
`endif
  );
  modport slave (
    input in_valid_i, op_i, inv_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o
`ifdef LAMP_SQRT_FLAGS_EN
    , flags_o
`endif
  );
endinterface

// File: rtl/lampfpu_sqrt_classify.sv
// lampfpu_sqrt_classify: operand class, special-case result and result exponent
module lampfpu_sqrt_classify
  import lampFPU_pkg::*;
(
  input  logic [LAMP_FLOAT_DW-1:0]   op,
  input  logic                       inv,
  output class_t                     cls,
  output logic [LAMP_FLOAT_DW-1:0]   spec_res,
  output logic [LAMP_FLOAT_E_DW-1:0] er,
  output logic                       exp_odd
);
  logic [LAMP_FLOAT_E_DW-1:0] e_b;
  logic [LAMP_FLOAT_F_DW-1:0] f;
  logic [LAMP_FLOAT_E_DW:0] ep;
  assign e_b = op[14:7];
  assign f = op[6:0];
  assign cls.is_zero = e_b == '0;
  assign cls.is_inf = &e_b && f == '0;
  assign cls.is_nan = &e_b && |f;
  assign cls.is_neg = op[15];
  // floor((E-127)/2) = ((E+1)>>1) - 64, and bit 0 of E+1 is the odd-exponent flag
  assign ep = {1'b0, e_b} + 9'd1;
  assign exp_odd = ep[0];
  assign er = inv ? 8'd191 - ep[8:1] : ep[8:1] + (BIAS - 8'd64);
  assign spec_res = (cls.is_nan || (cls.is_neg && !cls.is_zero)) ? QNAN :
                    cls.is_zero ? {op[15], inv ? PINF[14:0] : 15'h0} :
                    inv ? 16'h0000 : PINF;
endmodule

// File: rtl/lampfpu_sqrt_issue.sv
// lampfpu_sqrt_issue: operand/issue/pack sequencer around the Goldschmidt sqrt core (option LAMP_SQRT_FLAGS_EN)
module lampfpu_sqrt_issue
  import lampFPU_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  lampfpu_sqrt_issue_if.slave  io,
  output logic                 core_do_o,
  output logic [7:0]           core_s_o,
  output logic                 core_exp_odd_o,
  output logic                 core_inv_o,
  output logic                 core_special_o,
  input  logic                 core_valid_i,
  input  logic [7:0]           core_res_i
);
  state_t state;
  class_t cls;
  logic [LAMP_FLOAT_DW-1:0] spec_res, sres, nres;
  logic [LAMP_FLOAT_E_DW-1:0] er, er_q;
  logic [7:0] cres;
  logic exp_odd, special, spec_q;
  lampfpu_sqrt_classify u_cls (
    .op(io.op_i), .inv(io.inv_i), .cls(cls), .spec_res(spec_res), .er(er), .exp_odd(exp_odd)
  );
  assign special = cls.is_nan | cls.is_neg | cls.is_zero | cls.is_inf;
  assign io.in_ready_o = state == IDLE;
  assign io.out_valid_o = state == OUT;
  // core result 0 means it wrapped to 2.0; a clear MSB means it fell below 1.0
  always_comb
    nres = cres == 8'h00 ? {1'b0, er_q + 8'd1, 7'h00} :
           cres[7] ? {1'b0, er_q, cres[6:0]} :
           {1'b0, er_q - 8'd1, cres[5:0], 1'b0};
`ifdef LAMP_SQRT_FLAGS_EN
  logic [1:0] flg;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      io.res_o <= '0;
      core_do_o <= 1'b0;
      core_special_o <= 1'b0;
      core_s_o <= '0;
      core_exp_odd_o <= 1'b0;
      core_inv_o <= 1'b0;
      spec_q <= 1'b0;
      sres <= '0;
      er_q <= '0;
      cres <= '0;
`ifdef LAMP_SQRT_FLAGS_EN
      flg <= '0;
      io.flags_o <= '0;
`endif
    end else begin
      core_do_o <= 1'b0;
      core_special_o <= 1'b0;
      case (state)
        IDLE: if (io.in_valid_i) begin
          state <= ISSUE;
          core_do_o <= !special;
          core_special_o <= special;
          core_s_o <= {1'b1, io.op_i[6:0]};
          core_exp_odd_o <= exp_odd;
          core_inv_o <= io.inv_i;
          spec_q <= special;
          sres <= spec_res;
          er_q <= er;
`ifdef LAMP_SQRT_FLAGS_EN
          flg <= {cls.is_nan | (cls.is_neg & !cls.is_zero), io.inv_i & cls.is_zero};
`endif
        end
        ISSUE: state <= WAIT;
        WAIT: if (core_valid_i) begin
          cres <= core_res_i;
          state <= PACK;
        end
        PACK: begin
          io.res_o <= spec_q ? sres : nres;
`ifdef LAMP_SQRT_FLAGS_EN
          io.flags_o <= flg;
`endif
          state <= OUT;
        end
        OUT: if (io.out_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lampfpu_sqrt_issue.sv
// tb_lampfpu_sqrt_issue: directed checks of issue, pack, special values, backpressure and reset
module tb_lampfpu_sqrt_issue;
  logic clk = 1'b0;
  logic rst;
  logic core_do_o, core_exp_odd_o, core_inv_o, core_special_o, core_valid_i;
  logic [7:0] core_s_o, core_res_i;
  int checks = 0;
  int failures = 0;
  lampfpu_sqrt_issue_if bus ();
  lampfpu_sqrt_issue dut (
    .clk(clk), .rst(rst), .io(bus),
    .core_do_o(core_do_o), .core_s_o(core_s_o), .core_exp_odd_o(core_exp_odd_o),
    .core_inv_o(core_inv_o), .core_special_o(core_special_o),
    .core_valid_i(core_valid_i), .core_res_i(core_res_i)
  );
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [15:0] op, input logic inv, input logic sp, input int dly,
                     input logic [7:0] cr, input logic [15:0] exp_res, input logic odd,
                     input logic [1:0] fl, input int hold);
    int n = 0;
    while (!bus.in_ready_o && n < 20) begin
      tick();
      n++;
    end
    chk1("in_ready_idle", bus.in_ready_o, 1'b1);
    bus.in_valid_i = 1'b1;
    bus.op_i = op;
    bus.inv_i = inv;
    tick();
    bus.in_valid_i = 1'b0;
    bus.op_i = 16'hFFFF;
    bus.inv_i = !inv;
    chk1("issue_ready", bus.in_ready_o, 1'b0);
    chk1("issue_do", core_do_o, !sp);
    chk1("issue_special", core_special_o, sp);
    chk1("issue_inv", core_inv_o, inv);
    if (!sp) begin
      chk1("issue_odd", core_exp_odd_o, odd);
      chk16("issue_s", {8'h00, core_s_o}, {8'h00, 1'b1, op[6:0]});
    end
    tick();
    chk1("wait_do", core_do_o, 1'b0);
    chk1("wait_special", core_special_o, 1'b0);
    chk1("wait_inv", core_inv_o, inv);
    repeat (dly) tick();
    core_valid_i = 1'b1;
    core_res_i = cr;
    tick();
    core_valid_i = 1'b0;
    core_res_i = 8'h33;
    chk1("pack_valid", bus.out_valid_o, 1'b0);
    tick();
    chk1("out_valid", bus.out_valid_o, 1'b1);
    chk16("res", bus.res_o, exp_res);
`ifdef LAMP_SQRT_FLAGS_EN
    chk16("flags", {14'h0, bus.flags_o}, {14'h0, fl});
`else
    if (fl == 2'b11) $display("note: unexpected flag vector");
`endif
    repeat (hold) begin
      tick();
      chk16("hold_res", bus.res_o, exp_res);
      chk1("hold_valid", bus.out_valid_o, 1'b1);
      chk1("hold_ready", bus.in_ready_o, 1'b0);
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk1("done_ready", bus.in_ready_o, 1'b1);
    chk1("done_valid", bus.out_valid_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.op_i = 16'h0;
    bus.inv_i = 1'b0;
    bus.out_ready_i = 1'b0;
    core_valid_i = 1'b0;
    core_res_i = 8'h00;
    repeat (2) tick();
    chk16("rst_res", bus.res_o, 16'h0000);
    chk1("rst_valid", bus.out_valid_o, 1'b0);
    chk1("rst_ready", bus.in_ready_o, 1'b1);
    chk1("rst_do", core_do_o, 1'b0);
    chk1("rst_special", core_special_o, 1'b0);
    chk1("rst_odd", core_exp_odd_o, 1'b0);
    chk1("rst_inv", core_inv_o, 1'b0);
    chk16("rst_s", {8'h00, core_s_o}, 16'h0000);
    rst = 1'b0;
    tick();
    // op, inv, special, core delay, core result, expected res, odd, flags, hold
    run(16'h4080, 1'b0, 1'b0, 3, 8'h80, 16'h4000, 1'b0, 2'b00, 0);
    run(16'h4000, 1'b0, 1'b0, 5, 8'hB5, 16'h3FB5, 1'b1, 2'b00, 0);
    run(16'h4080, 1'b1, 1'b0, 2, 8'h80, 16'h3F00, 1'b0, 2'b00, 0);
    run(16'h4000, 1'b1, 1'b0, 4, 8'h5A, 16'h3F34, 1'b1, 2'b00, 0);
    run(16'h4080, 1'b0, 1'b0, 1, 8'h00, 16'h4080, 1'b0, 2'b00, 0);
    run(16'h3E80, 1'b0, 1'b0, 2, 8'h80, 16'h3F00, 1'b0, 2'b00, 0);
    run(16'h3F00, 1'b0, 1'b0, 0, 8'hB5, 16'h3F35, 1'b1, 2'b00, 5);
    run(16'hBF80, 1'b0, 1'b1, 0, 8'h80, 16'h7FC0, 1'b0, 2'b10, 0);
    run(16'h0000, 1'b1, 1'b1, 0, 8'h80, 16'h7F80, 1'b0, 2'b01, 0);
    run(16'h8000, 1'b0, 1'b1, 0, 8'h80, 16'h8000, 1'b0, 2'b00, 0);
    run(16'h8000, 1'b1, 1'b1, 0, 8'h80, 16'hFF80, 1'b0, 2'b01, 0);
    run(16'h0005, 1'b0, 1'b1, 0, 8'h80, 16'h0000, 1'b0, 2'b00, 0);
    run(16'h7F80, 1'b0, 1'b1, 0, 8'h80, 16'h7F80, 1'b0, 2'b00, 0);
    run(16'h7F80, 1'b1, 1'b1, 0, 8'h80, 16'h0000, 1'b0, 2'b00, 0);
    run(16'h7FC1, 1'b0, 1'b1, 0, 8'h80, 16'h7FC0, 1'b0, 2'b10, 0);
    run(16'hFF80, 1'b1, 1'b1, 0, 8'h80, 16'h7FC0, 1'b0, 2'b10, 0);
    bus.in_valid_i = 1'b1;
    bus.op_i = 16'h4080;
    bus.inv_i = 1'b0;
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    core_valid_i = 1'b1;
    core_res_i = 8'h80;
    tick();
    rst = 1'b0;
    core_valid_i = 1'b0;
    chk1("abort_valid", bus.out_valid_o, 1'b0);
    chk1("abort_ready", bus.in_ready_o, 1'b1);
    chk16("abort_res", bus.res_o, 16'h0000);
    repeat (3) tick();
    chk1("abort_idle_valid", bus.out_valid_o, 1'b0);
    chk1("abort_idle_ready", bus.in_ready_o, 1'b1);
    core_valid_i = 1'b1;
    tick();
    core_valid_i = 1'b0;
    tick();
    tick();
    chk1("stray_valid", bus.out_valid_o, 1'b0);
    chk1("stray_ready", bus.in_ready_o, 1'b1);
    run(16'h4000, 1'b0, 1'b0, 2, 8'hB5, 16'h3FB5, 1'b1, 2'b00, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lampfpu_sqrt_issue.md
# lampfpu_sqrt_issue

Front-end/back-end sequencer for the iterative Goldschmidt square-root core. It accepts a packed bfloat16-style operand with a valid/ready handshake, classifies special values and computes the result exponent. It then issues the normalized significand to the core over its command interface (doSqrt/special_case/valid/res). When the core completes, it normalizes and packs the 8-bit core result into a full float and holds it until the consumer accepts it.

## Interface
- Parameters: none. Widths come from lampFPU_pkg: LAMP_FLOAT_DW=16, LAMP_FLOAT_E_DW=8, LAMP_FLOAT_F_DW=7, bias 127.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  block can accept; high only in IDLE
- op_i  in  16  {sign, exp[7:0], frac[6:0]}
- inv_i  in  1  0 = sqrt, 1 = inverse sqrt
- out_valid_o  out  1  result valid; held until out_ready_i
- out_ready_i  in  1  consumer accepts
- res_o  out  16  packed result
- core_do_o  out  1  single-cycle start pulse (core doSqrt_i)
- core_s_o  out  8  {1'b1, frac} significand
- core_exp_odd_o  out  1  unbiased exponent odd
- core_inv_o  out  1  copy of latched inv_i
- core_special_o  out  1  single-cycle pulse for special operands
- core_valid_i  in  1  core result valid, 1-cycle pulse
- core_res_i  in  8  core result, 1.7 fixed point

## Operation
- States: IDLE, ISSUE, WAIT, PACK, OUT.
- IDLE -> ISSUE on in_valid_i && in_ready_o. Latch op_i and inv_i. Classify; E = op_i[14:7].
- ISSUE: drive the core-side outputs for exactly one cycle.
  - Normal operand: core_do_o=1.
  - Special operand: core_special_o=1, core_do_o=0.
  - core_s_o, core_exp_odd_o and core_inv_o are held stable from ISSUE through WAIT.
  - Next state WAIT.
- WAIT: remain until core_valid_i=1, then register core_res_i -> PACK.
- PACK -> OUT. Form res_o:
  - Special result: the precomputed constant; core_res_i is ignored.
  - Normal result:
    - If core_res_i==8'h00: treat as 2.0 (frac=0, exp+1).
    - Else if core_res_i[7]==0: shift left 1, exp-1.
    - Frac = normalized bits [6:0]. Sign 0.
- OUT -> IDLE on out_ready_i.
- Exponent arithmetic, signed 10-bit, no overflow possible for normal operands:
  - e = E-127; h = e>>>1 (floor).
  - core_exp_odd_o = ~E[0].
  - Sqrt result exponent Er = h+127; inverse sqrt Er = 127-h.
- Special cases, with the result fixed at classification:
  - NaN, or negative non-zero (including -inf): 16'h7FC0.
  - ±0 or denormal (E==0, flushed to zero): sqrt -> {sign,15'h0}; inv -> {sign,15'h7F80}.
  - +inf: sqrt -> 16'h7F80; inv -> 16'h0000.
- Reset values:
  - State IDLE; res_o=0.
  - out_valid_o, core_do_o, core_special_o, core_exp_odd_o, core_inv_o = 0; core_s_o = 0.
  - in_ready_o = 1 (IDLE).
- rst is shared with the core. Reset mid-operation aborts silently and drops any pending core_valid_i.
- core_valid_i outside WAIT is ignored.

## Timing
- Operand accepted at cycle T. ISSUE at T+1. core_valid_i seen at cycle V ≥ T+2. PACK at V+1. out_valid_o=1 from V+2.
- Special path: core_valid_i at T+2, out_valid_o at T+4.
- Normal path: latency = 3 + core iteration count.
- One operation in flight; in_ready_o=0 from T+1 until the cycle after the OUT handshake.
- No combinational path from in_valid_i or out_ready_i to any output.
- res_o is stable while out_valid_o=1.

## Configuration
- LAMP_SQRT_FLAGS_EN defined: adds port flags_o out 2 = {invalid, divzero}.
  - invalid: NaN input or negative non-zero.
  - divzero: inverse sqrt of ±0 or denormal.
  - Flags are valid with out_valid_o; reset 0.
- Undefined: the port is absent and no flag logic is built.

## Structure
- lampFPU_pkg holds:
  - Special-value constants: QNAN=16'h7FC0, PINF=16'h7F80.
  - BIAS=127.
  - The state enum typedef.
  - A classification struct {is_nan, is_zero, is_inf, is_neg}.
- One combinational sub-module, lampfpu_sqrt_classify: op_i, inv_i -> class struct, special result, Er, core_exp_odd.

## Test plan
- 16'h4080 (4.0), inv=0; core returns 8'h80 -> res_o=16'h4000, core_exp_odd_o=0.
- 16'h4000 (2.0), inv=0; core returns 8'hB5 -> core_exp_odd_o=1, res_o=16'h3FB5.
- 16'h4080, inv=1; core returns 8'h80 -> res_o=16'h3F00.
- 16'hBF80 (-1.0) -> core_special_o pulse, no core_do_o, res_o=16'h7FC0; invalid=1 with LAMP_SQRT_FLAGS_EN.
- 16'h0000 with inv=1 -> res_o=16'h7F80, divzero=1.
- Backpressure/reset:
  - Hold out_ready_i=0 for 5 cycles: res_o is stable and in_ready_o=0.
  - Assert rst during WAIT: out_valid_o=0 and in_ready_o=1 on the next cycle.
